fifo_buf: RTL and testbench

- Synchronous result FIFO that buffers 8-bit results from the compute stages.
- Its fifo_data output drives the fifo_data input of mux_out, which places it on D_OUT when SEL_OUT = 3'b000.
- Write and read share one clock.
- Flags (full, empty, occupancy, sticky overflow/underflow) let the controller pace writes and reads.

---
 rtl/fifo_buf.sv | 106 ++++++++++
 tb/tb_fifo_buf.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_buf.sv
// Synchronous result FIFO: single clock, registered read data and flags,
// sticky overflow/underflow. fifo_data feeds mux_out.
module fifo_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              CLKEXT,
  input  logic              RST_GLO,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] fifo_data,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  output logic              udf
);

  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LP_CNT1  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] LP_PTR1  = ADDR_W'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wptr;
  logic [ADDR_W-1:0] r_rptr;
  logic [ADDR_W:0]   r_count;
  logic              r_full;
  logic              r_empty;
  logic [DATA_W-1:0] r_data;
  logic              r_ovf;
  logic              r_udf;

  logic              w_push;
  logic              w_pop;
  logic [ADDR_W:0]   w_count_nxt;

  // A push at full is allowed only when a pop frees a slot in the same edge.
  assign w_push = wr_en & (~r_full | rd_en);
  assign w_pop  = rd_en & ~r_empty;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + LP_CNT1;
      2'b01:   w_count_nxt = r_count - LP_CNT1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array carries no reset; entries are only read after being written.
  always_ff @(posedge CLKEXT) begin
    if (w_push && !clr && !RST_GLO) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_data  <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else if (clr) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_data  <= '0;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + LP_PTR1;
      end
      if (w_pop) begin
        r_data <= r_mem[r_rptr];
        r_rptr <= r_rptr + LP_PTR1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == LP_DEPTH);
      r_empty <= (w_count_nxt == '0);
      if (wr_en && !w_push) begin
        r_ovf <= 1'b1;
      end
      if (rd_en && !w_pop) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign fifo_data = r_data;
  assign full      = r_full;
  assign empty     = r_empty;
  assign count     = r_count;
  assign ovf       = r_ovf;
  assign udf       = r_udf;

endmodule

// File: tb/tb_fifo_buf.sv
// Self-checking bench for fifo_buf: directed corner cases plus random traffic,
// all compared against a queue-based reference model.
module tb_fifo_buf;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              CLKEXT;
  logic              RST_GLO;
  logic              clr;
  logic              wr_en;
  logic [DATA_W-1:0] din;
  logic              rd_en;
  logic [DATA_W-1:0] fifo_data;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              ovf;
  logic              udf;

  fifo_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLKEXT(CLKEXT), .RST_GLO(RST_GLO), .clr(clr), .wr_en(wr_en), .din(din),
    .rd_en(rd_en), .fifo_data(fifo_data), .full(full), .empty(empty),
    .count(count), .ovf(ovf), .udf(udf)
  );

  initial CLKEXT = 1'b0;
  always #5 CLKEXT = ~CLKEXT;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] m_data;
  logic              m_ovf;
  logic              m_udf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_data = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic w, input logic r, input logic [DATA_W-1:0] d);
    bit was_full, was_empty, push_ok, pop_ok;
    if (c) begin
      model_reset();
    end else begin
      was_full  = (m_q.size() == DEPTH);
      was_empty = (m_q.size() == 0);
      push_ok   = w && (!was_full || r);
      pop_ok    = r && !was_empty;
      if (pop_ok) m_data = m_q.pop_front();
      if (push_ok) m_q.push_back(d);
      if (w && !push_ok) m_ovf = 1'b1;
      if (r && !pop_ok) m_udf = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"},  32'(fifo_data), 32'(m_data));
    check({tag, ".count"}, 32'(count),     32'(m_q.size()));
    check({tag, ".full"},  32'(full),      32'(m_q.size() == DEPTH));
    check({tag, ".empty"}, 32'(empty),     32'(m_q.size() == 0));
    check({tag, ".ovf"},   32'(ovf),       32'(m_ovf));
    check({tag, ".udf"},   32'(udf),       32'(m_udf));
  endtask

  // One clock: drive inputs, update the model at the edge, sample 1 ns later.
  task automatic cyc(input string tag, input logic c, input logic w, input logic r, input logic [DATA_W-1:0] d);
    clr = c; wr_en = w; rd_en = r; din = d;
    @(posedge CLKEXT);
    model_step(c, w, r, d);
    #1;
    check_all(tag);
    clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  initial begin
    RST_GLO = 1'b1; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;
    model_reset();
    #10;
    RST_GLO = 1'b0;
    #1;
    check_all("reset");

    // fill/drain order
    begin
      logic [DATA_W-1:0] pat [5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5};
      for (int i = 0; i < 5; i++) cyc("fill5", 1'b0, 1'b1, 1'b0, pat[i]);
      check("fill5.count_const", 32'(count), 32'd5);
      for (int i = 0; i < 5; i++) begin
        cyc("drain5", 1'b0, 1'b0, 1'b1, '0);
        check("drain5.order", 32'(fifo_data), 32'(pat[i]));
      end
      check("drain5.empty_const", 32'(empty), 32'd1);
    end

    // full and overflow
    for (int i = 0; i < 8; i++) cyc("fill8", 1'b0, 1'b1, 1'b0, 8'(8'h10 + i));
    check("fill8.full_const", 32'(full), 32'd1);
    cyc("ovf_push", 1'b0, 1'b1, 1'b0, 8'hFF);
    check("ovf_push.ovf_const", 32'(ovf), 32'd1);
    check("ovf_push.count_const", 32'(count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      cyc("drain8", 1'b0, 1'b0, 1'b1, '0);
      check("drain8.order", 32'(fifo_data), 32'(8'h10 + i));
    end
    cyc("clr1", 1'b1, 1'b0, 1'b0, '0);

    // simultaneous push/pop at full
    for (int i = 0; i < 8; i++) cyc("fill8b", 1'b0, 1'b1, 1'b0, 8'(8'h20 + i));
    cyc("both_full", 1'b0, 1'b1, 1'b1, 8'h55);
    check("both_full.data_const", 32'(fifo_data), 32'h20);
    check("both_full.count_const", 32'(count), 32'd8);
    check("both_full.ovf_const", 32'(ovf), 32'd0);
    for (int i = 0; i < 8; i++) cyc("drain_55", 1'b0, 1'b0, 1'b1, '0);
    check("drain_55.last", 32'(fifo_data), 32'h55);

    // empty corner cases
    cyc("pop_empty", 1'b0, 1'b0, 1'b1, '0);
    check("pop_empty.udf_const", 32'(udf), 32'd1);
    check("pop_empty.hold", 32'(fifo_data), 32'h55);
    cyc("both_empty", 1'b0, 1'b1, 1'b1, 8'h3C);
    check("both_empty.count_const", 32'(count), 32'd1);
    cyc("pop_3c", 1'b0, 1'b0, 1'b1, '0);
    check("pop_3c.data_const", 32'(fifo_data), 32'h3C);

    // wrap with push/pop pairs
    cyc("clr2", 1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 20; i++) begin
      cyc("wrap_push", 1'b0, 1'b1, 1'b0, 8'(i));
      cyc("wrap_pop", 1'b0, 1'b0, 1'b1, '0);
      check("wrap.order", 32'(fifo_data), 32'(i));
    end

    // clear mid-stream
    for (int i = 0; i < 3; i++) cyc("pre_clr", 1'b0, 1'b1, 1'b0, 8'(8'h90 + i));
    cyc("clr3", 1'b1, 1'b1, 1'b1, 8'hAA);
    check("clr3.count_const", 32'(count), 32'd0);
    check("clr3.data_const", 32'(fifo_data), 32'd0);

    // asynchronous reset between edges
    for (int i = 0; i < 2; i++) cyc("pre_rst", 1'b0, 1'b1, 1'b0, 8'(8'h70 + i));
    cyc("pre_rst_pop", 1'b0, 1'b0, 1'b1, '0);
    #2;
    RST_GLO = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    #1;
    RST_GLO = 1'b0;
    cyc("post_rst", 1'b0, 1'b1, 1'b0, 8'h42);
    cyc("post_rst_pop", 1'b0, 1'b0, 1'b1, '0);
    check("post_rst.data_const", 32'(fifo_data), 32'h42);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic c, w, r;
      int bias;
      bias = (i / 100) % 2;
      c = ($urandom_range(0, 59) == 0);
      w = (bias == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      r = (bias == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cyc("rand", c, w, r, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
